ysyx_25040111_lsu: RTL
======================

# ysyx_25040111_lsu

Load/store and writeback unit. It is the receiving end of the execute-stage "abt" handshake. It accepts one executed instruction at a time, performs the data-memory access if one is required, and commits results to the GPR and CSR write ports. It returns `abt_finish` so execute can release its load-use register lock. It sits between the execute unit and the data-side memory bus.

## Interface
Parameters: none; widths are fixed by the core.

Ports:
- `clock` in 1: core clock.
- `reset` in 1: synchronous, active-high.
- `abt_valid` in 1: an executed instruction is presented.
- `abt_ready` out 1: unit can accept an instruction.
- `abt_men` in 1: instruction needs a memory access.
- `abt_write` in 1: 1 = store, 0 = load. Meaningful only when `abt_men` is 1.
- `abt_addr` in 32: byte address.
- `abt_wdata` in 32: store data, right-aligned.
- `abt_mask` in 2: access size. 01 = byte, 10 = half, 11 = word.
- `abt_rsign` in 1: sign-extend the load result.
- `abt_ard` in 5: GPR destination index.
- `abt_rd` in 32: GPR result for non-load instructions.
- `abt_gen` in 1: GPR write enable.
- `abt_acsr` in 12: CSR destination index.
- `abt_csr` in 32: CSR write data.
- `abt_sen` in 1: CSR write enable.
- `abt_finish` out 1: one-cycle pulse when the instruction retires.
- `mem_req_valid` out 1, `mem_req_ready` in 1: memory request handshake.
- `mem_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_write` out 1: request is a store.
- `mem_wdata` out 32: lane-shifted store data.
- `mem_wstrb` out 4: byte-lane strobes.
- `mem_rsp_valid` in 1, `mem_rsp_ready` out 1: memory response handshake.
- `mem_rdata` in 32: read data.
- `gpr_wen` out 1, `gpr_waddr` out 5, `gpr_wdata` out 32: GPR write port.
- `csr_wen` out 1, `csr_waddr` out 12, `csr_wdata` out 32: CSR write port.
- `misalign` out 1: one-cycle pulse when a misaligned access is dropped.

## Operation
- The FSM has four states: IDLE, REQ, RESP, WB. `abt_ready` = (state == IDLE).
- On accept (`abt_valid & abt_ready`), the unit latches every `abt_*` input.
- From IDLE on accept:
  - to REQ if `abt_men` is 1 and the access is aligned;
  - otherwise to WB.
- Misaligned means: half with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0. A misaligned access issues no bus request, forces the load result to 0, and pulses `misalign` in the WB cycle.
- REQ: drive `mem_req_valid`. Leave for RESP on `mem_req_ready`.
- RESP: drive `mem_rsp_ready`. Leave for WB on `mem_rsp_valid`.
  - For loads, latch the aligned and extended data.
  - For stores, the response is an acknowledge only and `mem_rdata` is ignored.
- WB lasts one cycle, then the FSM returns to IDLE. In WB:
  - `gpr_wen` = gen & (ard ≠ 0).
  - `gpr_wdata` = load result if (men & ~write), else the latched `abt_rd`.
  - `csr_wen` = sen.
  - `abt_finish` = 1.
- Store lanes: `mem_wstrb` is 0001, 0011 or 1111 shifted left by `addr[1:0]`. `mem_wdata` = wdata shifted left by 8·`addr[1:0]`.
- Load: shift `mem_rdata` right by 8·`addr[1:0]`, keep 8, 16 or 32 bits, then sign-extend if `rsign`, otherwise zero-extend.

## Timing
- Reset: state = IDLE. Every output is 0 except `abt_ready` = 1. Latched fields are cleared.
- Non-memory instruction: accepted at T, writeback and `abt_finish` at T+1, ready again at T+2.
- Memory access with zero-wait bus: accept at T, REQ at T+1, RESP at T+2 with `mem_rsp_valid`, WB at T+3.
- `mem_req_valid` and the request fields stay stable until `mem_req_ready` is seen.
- A response is never accepted in REQ. `mem_rsp_valid` in IDLE is ignored, because `mem_rsp_ready` is 0 there.
- Reset in REQ or RESP aborts the instruction: no writeback, no `abt_finish`.
- The GPR write and `abt_finish` occur in the same cycle. The lock released by execute therefore never exposes a stale register.

## Structure
- Add to `ysyx_25040111_inc.vh`:
  - mask encodings: `MASK_B`, `MASK_H`, `MASK_W`;
  - FSM state encodings: `LSU_IDLE`, `LSU_REQ`, `LSU_RESP`, `LSU_WB`.
- Sub-module `ysyx_25040111_lsu_align` (combinational):
  - store lane shift and strobe generation;
  - load extract and extend;
  - misalignment detect.

## Test plan
- Non-memory op: `gen`=1, `ard`=5, `rd`=0x1234 → x5 = 0x1234 and `finish` at T+1; `abt_ready` low for exactly 1 cycle.
- Store byte, addr 0x80000003, wdata 0xAB → `wstrb`=1000, `wdata`=0xAB000000, `mem_addr`=0x80000000, no GPR write.
- Load half signed, addr 0x..02, rdata 0x8001FFFF → GPR = 0xFFFF8001. Same access unsigned → 0x00008001.
- Load word with `mem_req_ready` delayed 3 cycles and response delayed 2 → request fields stable throughout; exactly one `finish` pulse.
- Word load at addr 0x..01 → no bus request, `misalign` pulse, GPR = 0.
- CSR op (`sen`=1, `acsr`=0x300, `csr`=0x88, `gen`=1, `rd`=old value) → both ports write in the same WB cycle. Separately, reset asserted in RESP → IDLE next cycle with no writeback.

Source files
------------

// File: rtl/ysyx_25040111_lsu_pkg.sv
// Shared encodings for the load/store/writeback unit: access sizes, FSM states
// and the bundle of instruction fields captured on accept.
package ysyx_25040111_lsu_pkg;

  localparam logic [1:0] MASK_B = 2'b01;
  localparam logic [1:0] MASK_H = 2'b10;
  localparam logic [1:0] MASK_W = 2'b11;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2,
    LSU_WB   = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic        men;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  mask;
    logic        rsign;
    logic [4:0]  ard;
    logic [31:0] rd;
    logic        gen;
    logic [11:0] acsr;
    logic [31:0] csr;
    logic        sen;
  } abt_fields_t;

endpackage

// File: rtl/ysyx_25040111_lsu_align.sv
// Combinational byte-lane logic: store shift/strobes, load extract/extend and
// misalignment detection for the LSU.
module ysyx_25040111_lsu_align
  import ysyx_25040111_lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  mask,
  input  logic        rsign,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] lane_wdata,
  output logic [3:0]  lane_wstrb,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [4:0]  shamt;
  logic [31:0] rdata_shifted;

  assign shamt         = {addr_lo, 3'b000};
  assign lane_wdata    = wdata << shamt;
  assign rdata_shifted = rdata >> shamt;

  always_comb begin
    lane_wstrb = 4'b0000;
    load_data  = 32'h0;
    misaligned = 1'b0;
    case (mask)
      MASK_B: begin
        lane_wstrb = 4'b0001 << addr_lo;
        load_data  = {{24{rsign & rdata_shifted[7]}}, rdata_shifted[7:0]};
      end
      MASK_H: begin
        lane_wstrb = 4'b0011 << addr_lo;
        load_data  = {{16{rsign & rdata_shifted[15]}}, rdata_shifted[15:0]};
        misaligned = addr_lo[0];
      end
      MASK_W: begin
        lane_wstrb = 4'b1111;
        load_data  = rdata_shifted;
        misaligned = (addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_25040111_lsu.sv
// Load/store and writeback unit: accepts one executed instruction, performs the
// optional data-bus access, then commits GPR/CSR results with abt_finish.
module ysyx_25040111_lsu
  import ysyx_25040111_lsu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        abt_valid,
  output logic        abt_ready,
  input  logic        abt_men,
  input  logic        abt_write,
  input  logic [31:0] abt_addr,
  input  logic [31:0] abt_wdata,
  input  logic [1:0]  abt_mask,
  input  logic        abt_rsign,
  input  logic [4:0]  abt_ard,
  input  logic [31:0] abt_rd,
  input  logic        abt_gen,
  input  logic [11:0] abt_acsr,
  input  logic [31:0] abt_csr,
  input  logic        abt_sen,
  output logic        abt_finish,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rsp_valid,
  output logic        mem_rsp_ready,
  input  logic [31:0] mem_rdata,
  output logic        gpr_wen,
  output logic [4:0]  gpr_waddr,
  output logic [31:0] gpr_wdata,
  output logic        csr_wen,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        misalign
);

  lsu_state_e  state_q, state_d;
  abt_fields_t fields_q, fields_d;
  logic [31:0] load_q, load_d;

  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;
  logic [31:0] load_data;
  logic        misaligned;
  logic        accept;
  logic        is_load;
  logic        in_wb;
  abt_fields_t fields_in;

  ysyx_25040111_lsu_align u_align (
    .addr_lo    (fields_q.addr[1:0]),
    .mask       (fields_q.mask),
    .rsign      (fields_q.rsign),
    .wdata      (fields_q.wdata),
    .rdata      (mem_rdata),
    .lane_wdata (lane_wdata),
    .lane_wstrb (lane_wstrb),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  // Misalignment of the incoming access decides the IDLE exit, so check it
  // directly on the abt inputs rather than on the latched copy.
  logic in_misaligned;
  always_comb begin
    in_misaligned = 1'b0;
    case (abt_mask)
      MASK_H:  in_misaligned = abt_addr[0];
      MASK_W:  in_misaligned = (abt_addr[1:0] != 2'b00);
      default: in_misaligned = 1'b0;
    endcase
  end

  assign fields_in = '{
    men:   abt_men,   write: abt_write, addr:  abt_addr, wdata: abt_wdata,
    mask:  abt_mask,  rsign: abt_rsign, ard:   abt_ard,  rd:    abt_rd,
    gen:   abt_gen,   acsr:  abt_acsr,  csr:   abt_csr,  sen:   abt_sen
  };

  assign abt_ready = (state_q == LSU_IDLE);
  assign accept    = abt_valid & abt_ready;
  assign is_load   = fields_q.men & ~fields_q.write;
  assign in_wb     = (state_q == LSU_WB);

  always_comb begin
    state_d  = state_q;
    fields_d = fields_q;
    load_d   = load_q;
    case (state_q)
      LSU_IDLE: begin
        if (accept) begin
          fields_d = fields_in;
          state_d  = (abt_men & ~in_misaligned) ? LSU_REQ : LSU_WB;
        end
      end
      LSU_REQ: begin
        if (mem_req_ready) state_d = LSU_RESP;
      end
      LSU_RESP: begin
        if (mem_rsp_valid) begin
          state_d = LSU_WB;
          if (is_load) load_d = load_data;
        end
      end
      LSU_WB:   state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= LSU_IDLE;
      fields_q <= '0;
      load_q   <= 32'h0;
    end else begin
      state_q  <= state_d;
      fields_q <= fields_d;
      load_q   <= load_d;
    end
  end

  // Request fields come from latched state so they hold steady while stalled.
  assign mem_req_valid = (state_q == LSU_REQ);
  assign mem_rsp_ready = (state_q == LSU_RESP);
  assign mem_addr      = {fields_q.addr[31:2], 2'b00};
  assign mem_write     = fields_q.write;
  assign mem_wdata     = lane_wdata;
  assign mem_wstrb     = lane_wstrb;

  assign abt_finish = in_wb;
  assign misalign   = in_wb & fields_q.men & misaligned;
  assign gpr_wen    = in_wb & fields_q.gen & (fields_q.ard != 5'd0);
  assign gpr_waddr  = fields_q.ard;
  assign gpr_wdata  = is_load ? (misaligned ? 32'h0 : load_q) : fields_q.rd;
  assign csr_wen    = in_wb & fields_q.sen;
  assign csr_waddr  = fields_q.acsr;
  assign csr_wdata  = fields_q.csr;

endmodule
